// File: rtl/divmmc_pager_if.sv
// Z80-side bus bundle for the divMMC pager: CPU strobes/address/data in,
// register readback and memory-select decode out.
interface divmmc_pager_if;
  logic        cep;
  logic        mreq, iorq, m1, rd, wr;
  logic [15:0] a;
  logic [7:0]  d;
  logic [7:0]  q;
  logic        qe;
  logic        map;
  logic        romSel, ramSel, ramWe;
  logic [3:0]  ramBank;

  modport master (
    output cep, mreq, iorq, m1, rd, wr, a, d,
    input  q, qe, map, romSel, ramSel, ramBank, ramWe
  );
  modport slave (
    input  cep, mreq, iorq, m1, rd, wr, a, d,
    output q, qe, map, romSel, ramSel, ramBank, ramWe
  );
endinterface

// File: rtl/divmmc_pager.sv
// divMMC paging: control port 0xE3 plus automap FSM with delayed/instant entry points.
// Optional macro DIVMMC_MAPRAM_EN enables the set-only MAPRAM bit.
module divmmc_pager (
  input  logic            clock28,
  input  logic            reset,
  divmmc_pager_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, PEND_MAP = 2'd1, PEND_UNMAP = 2'd2} state_t;

  state_t      state, state_nx;
  logic        conmem, mapram, automap, automap_nx;
  logic [3:0]  bank, bank_hold, bank_cur;
  logic        port_hit, port_wr, fetch, entry, instant, exit_hit;
  logic        low_win, high_win;
  logic        unused_bits;

  assign port_hit = !bus.iorq && (bus.a[7:0] == 8'hE3);
  assign port_wr  = bus.cep && port_hit && !bus.wr;
  assign fetch    = bus.cep && !bus.m1 && !bus.mreq;
  assign entry    = fetch && (bus.a inside {16'h0000, 16'h0008, 16'h0038,
                                            16'h0066, 16'h04C6, 16'h0562});
  assign instant  = fetch && (bus.a[15:8] == 8'h3D);
  assign exit_hit = fetch && (bus.a[15:3] == 13'h03FF);

  // A pending action resolves on the first enabled cycle with mreq high,
  // so the end of one fetch always precedes the start of the next.
  always_comb begin
    state_nx   = state;
    automap_nx = automap;
    case (state)
      IDLE: begin
        if (entry)         state_nx = PEND_MAP;
        else if (exit_hit) state_nx = PEND_UNMAP;
        if (instant)       automap_nx = 1'b1;
      end
      PEND_MAP:
        if (bus.cep && bus.mreq) begin
          state_nx   = IDLE;
          automap_nx = 1'b1;
        end
      PEND_UNMAP:
        if (bus.cep && bus.mreq) begin
          state_nx   = IDLE;
          automap_nx = 1'b0;
        end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock28 or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      automap <= 1'b0;
      conmem  <= 1'b0;
      bank    <= 4'd0;
    end else begin
      state   <= state_nx;
      automap <= automap_nx;
      if (port_wr) begin
        conmem <= bus.d[7];
        bank   <= bus.d[3:0];
      end
    end
  end

`ifdef DIVMMC_MAPRAM_EN
  // MAPRAM can only be set by software; only reset clears it.
  always_ff @(posedge clock28 or negedge reset) begin
    if (!reset)                   mapram <= 1'b0;
    else if (port_wr && bus.d[6]) mapram <= 1'b1;
  end
  assign unused_bits = ^bus.d[5:4];
`else
  assign mapram      = 1'b0;
  assign unused_bits = ^bus.d[6:4];
`endif

  assign bus.map = conmem | automap;
  assign low_win  = bus.map && (bus.a[15:13] == 3'b000);
  assign high_win = bus.map && (bus.a[15:13] == 3'b001);

  assign bus.romSel = low_win && (conmem || !mapram);
  assign bus.ramSel = (low_win && !conmem && mapram) || high_win;
  assign bus.ramWe  = high_win && !(mapram && (bank == 4'd3));
  assign bank_cur   = low_win ? 4'd3 : bank;

  // Bank output keeps the last selected bank while no RAM is selected.
  always_ff @(posedge clock28 or negedge reset) begin
    if (!reset)          bank_hold <= 4'd0;
    else if (bus.ramSel) bank_hold <= bank_cur;
  end
  assign bus.ramBank = bus.ramSel ? bank_cur : bank_hold;

  assign bus.qe = port_hit && !bus.rd;
  assign bus.q  = {conmem, mapram, 2'b00, bank};
endmodule

// File: tb/tb_divmmc_pager.sv
// Self-checking bench for divmmc_pager: directed scenarios then random bus
// cycles against a behavioural paging model.
module tb_divmmc_pager;
  logic clock28 = 1'b0;
  logic reset   = 1'b0;

  divmmc_pager_if bus();
  divmmc_pager dut (.clock28(clock28), .reset(reset), .bus(bus));

  always #5 clock28 = ~clock28;

  int nvec = 0, nerr = 0;

  // reference model state
  bit       m_conmem, m_mapram, m_automap;
  logic [3:0] m_bank;
  int       m_pend;          // +1 map pending, -1 unmap pending, 0 none
  bit       last_mreq = 1'b1;
  bit       dut_idle  = 1'b1;
  int       entries [6] = '{'h0000, 'h0008, 'h0038, 'h0066, 'h04C6, 'h0562};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_conmem = 0; m_mapram = 0; m_automap = 0; m_bank = 0; m_pend = 0;
    last_mreq = 1'b1;
  endtask

  task automatic drive(input bit cep, input bit mreq, input bit iorq, input bit m1,
                       input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
    bus.cep = cep; bus.mreq = mreq; bus.iorq = iorq; bus.m1 = m1;
    bus.rd = rd; bus.wr = wr; bus.a = a; bus.d = d;
  endtask

  task automatic model_step();
    bit fetch;
    int addr;
    if (!reset) begin model_clear(); return; end
    if (!bus.cep) return;
    fetch = !bus.m1 && !bus.mreq;
    addr  = int'(bus.a);
    if (fetch && last_mreq) chk("no_overlap", {31'd0, dut_idle}, 1);
    if (!bus.iorq && bus.a[7:0] == 8'hE3 && !bus.wr) begin
      m_conmem = bus.d[7];
`ifdef DIVMMC_MAPRAM_EN
      m_mapram = m_mapram | bus.d[6];
`endif
      m_bank = bus.d[3:0];
    end
    if (m_pend != 0) begin
      if (bus.mreq) begin
        m_automap = (m_pend > 0);
        m_pend = 0;
      end
    end else if (fetch) begin
      foreach (entries[i]) if (addr == entries[i]) m_pend = 1;
      if (addr / 256 == 'h3D) m_automap = 1;
      if (addr >= 'h1FF8 && addr <= 'h1FFF) m_pend = -1;
    end
    last_mreq = bus.mreq;
  endtask

  task automatic compare_all();
    int region;
    bit em, er, ers, ew, eqe;
    logic [3:0] eb;
    region = int'(bus.a) / 8192;
    em = m_conmem | m_automap;
    er = 0; ers = 0; ew = 0; eb = 0;
    if (em && region == 0) begin
      if (m_conmem || !m_mapram) er = 1;
      else begin ers = 1; eb = 3; ew = 0; end
    end else if (em && region == 1) begin
      ers = 1; eb = m_bank; ew = !(m_mapram && m_bank == 4'd3);
    end
    eqe = !bus.iorq && bus.a[7:0] == 8'hE3 && !bus.rd;
    chk("map", {31'd0, bus.map}, {31'd0, em});
    chk("romSel", {31'd0, bus.romSel}, {31'd0, er});
    chk("ramSel", {31'd0, bus.ramSel}, {31'd0, ers});
    chk("ramWe", {31'd0, bus.ramWe}, {31'd0, ew});
    chk("qe", {31'd0, bus.qe}, {31'd0, eqe});
    chk("q", {24'd0, bus.q}, {24'd0, m_conmem, m_mapram, 2'b00, m_bank});
    if (ers) chk("ramBank", {28'd0, bus.ramBank}, {28'd0, eb});
  endtask

  task automatic cyc();
    @(posedge clock28);
    model_step();
    #1;
    compare_all();
    dut_idle = (dut.state == 2'd0);
  endtask

  task automatic idle(input logic [15:0] a);
    drive(1, 1, 1, 1, 1, 1, a, 8'h00);
    cyc();
  endtask

  task automatic io_wr(input logic [7:0] d);
    drive(1, 1, 0, 1, 1, 0, 16'h00E3, d);
    cyc();
    idle(16'h0000);
  endtask

  task automatic io_rd_chk(input string tag, input logic [7:0] exp);
    drive(0, 1, 0, 1, 0, 1, 16'h00E3, 8'h00);
    cyc();
    chk({tag, "_qe"}, {31'd0, bus.qe}, 1);
    chk(tag, {24'd0, bus.q}, {24'd0, exp});
  endtask

  task automatic fetch(input logic [15:0] a);
    drive(1, 0, 1, 0, 0, 1, a, 8'h00);
    cyc();
  endtask

  task automatic mem_rd(input logic [15:0] a);
    drive(0, 0, 1, 1, 0, 1, a, 8'h00);
    cyc();
  endtask

  initial begin
    int kind, n;
    logic [15:0] addr;
    model_clear();
    drive(0, 1, 0, 1, 0, 1, 16'h00E3, 8'hFF);
    #2;
    chk("rst_map", {31'd0, bus.map}, 0);
    chk("rst_q", {24'd0, bus.q}, 0);
    chk("rst_romSel", {31'd0, bus.romSel}, 0);
    chk("rst_ramSel", {31'd0, bus.ramSel}, 0);
    #20 reset = 1'b1;
    idle(16'h0000);

    // port write/readback and decode
    io_wr(8'h83);
    io_rd_chk("q_83", 8'h83);
    mem_rd(16'h2000);
    chk("ram2000_sel", {31'd0, bus.ramSel}, 1);
    chk("ram2000_bank", {28'd0, bus.ramBank}, 3);
    chk("ram2000_we", {31'd0, bus.ramWe}, 1);
    mem_rd(16'h0000);
    chk("rom0000_sel", {31'd0, bus.romSel}, 1);
    io_wr(8'h00);

    // delayed map at 0x0038, delayed unmap at 0x1FFA
    fetch(16'h0038);
    chk("map_during_38", {31'd0, bus.map}, 0);
    fetch(16'h0038);
    idle(16'h0038);
    chk("map_after_38", {31'd0, bus.map}, 1);
    fetch(16'h1FFA);
    chk("map_during_1ffa", {31'd0, bus.map}, 1);
    idle(16'h1FFA);
    chk("map_after_1ffa", {31'd0, bus.map}, 0);

    // instant map at 0x3D2F
    fetch(16'h3D2F);
    chk("map_instant_3d", {31'd0, bus.map}, 1);
    idle(16'h3D2F);
    fetch(16'h1FF8);
    idle(16'h1FF8);
    mem_rd(16'h0066);
    idle(16'h0066);
    chk("map_nonm1_66", {31'd0, bus.map}, 0);

    // MAPRAM behaviour
    io_wr(8'h40);
    io_wr(8'h03);
`ifdef DIVMMC_MAPRAM_EN
    io_rd_chk("q_43", 8'h43);
`else
    io_rd_chk("q_03", 8'h03);
`endif
    fetch(16'h3D00);
    idle(16'h3D00);
    mem_rd(16'h0100);
`ifdef DIVMMC_MAPRAM_EN
    chk("mr_ramSel", {31'd0, bus.ramSel}, 1);
    chk("mr_ramBank", {28'd0, bus.ramBank}, 3);
    chk("mr_ramWe", {31'd0, bus.ramWe}, 0);
    io_wr(8'h00);
    io_rd_chk("q_40", 8'h40);
`else
    chk("mr_romSel", {31'd0, bus.romSel}, 1);
    io_wr(8'h00);
    io_rd_chk("q_00", 8'h00);
`endif

    // reset while map pending
    fetch(16'h0000);
    drive(1, 1, 1, 1, 1, 1, 16'h0000, 8'h00);
    reset = 1'b0;
    model_clear();
    cyc();
    cyc();
    reset = 1'b1;
    idle(16'h0000);
    chk("rst_pend_map", {31'd0, bus.map}, 0);
    chk("rst_pend_idle", {31'd0, dut_idle}, 1);
    io_rd_chk("rst_pend_q", 8'h00);

    // port write coincident with end of unmap fetch
    fetch(16'h3D00);
    idle(16'h3D00);
    fetch(16'h1FF8);
    drive(1, 1, 0, 1, 1, 0, 16'h00E3, 8'h80);
    cyc();
    chk("coinc_map", {31'd0, bus.map}, 1);
    io_rd_chk("coinc_q", 8'h80);
    io_wr(8'h00);
    chk("coinc_automap_off", {31'd0, bus.map}, 0);

    // random bus cycles
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 6);
      n = $urandom_range(1, 3);
      case ($urandom_range(0, 7))
        0: addr = 16'(entries[$urandom_range(0, 5)]);
        1: addr = 16'h3D00 | 16'($urandom_range(0, 255));
        2: addr = 16'h1FF8 | 16'($urandom_range(0, 7));
        3: addr = {8'($urandom_range(0, 255)), 8'hE3};
        default: addr = 16'($urandom_range(0, 16'h7FFF));
      endcase
      for (int k = 0; k < n; k++) begin
        case (kind)
          0, 1: drive(1'($urandom_range(0, 1)), 0, 1, 0, 0, 1, addr, 8'h00);
          2:    drive(1'($urandom_range(0, 1)), 0, 1, 1, 0, 1, addr, 8'h00);
          3:    drive(1'($urandom_range(0, 1)), 0, 1, 1, 1, 0, addr, 8'h00);
          4:    drive(1'($urandom_range(0, 1)), 1, 0, 1, 1, 0,
                      {8'($urandom_range(0, 255)), 8'hE3}, 8'($urandom_range(0, 255)));
          5:    drive(1'($urandom_range(0, 1)), 1, 0, 1, 0, 1, addr, 8'h00);
          default: drive(1'($urandom_range(0, 1)), 1, 1, 1, 1, 1, addr, 8'h00);
        endcase
        cyc();
      end
      for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
        drive(1'($urandom_range(0, 1)), 1, 1, 1, 1, 1, addr, 8'h00);
        cyc();
      end
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_clear();
        cyc();
        reset = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/divmmc_pager.md
DIVMMC_PAGER -- requirements
Module: divmmc_pager

Interface
REQ-001 clock28  in  1  system clock; all state changes on its rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 cep  in  1  CPU clock-enable; bus signals are sampled only when cep=1.
REQ-004 mreq, iorq, m1, rd, wr  in  1 each  Z80 bus strobes, active-low.
REQ-005 a  in  16  CPU address bus.
REQ-006 d  in  8  CPU data out, used for port writes.
REQ-007 q  out  8  control register readback.
REQ-008 qe  out  1  high while an I/O read of port 0xE3 is active; the top-level mux selects q when qe=1.
REQ-009 map  out  1  divMMC memory is paged into 0x0000-0x3FFF.
REQ-010 romSel  out  1  access targets the divMMC 8K ROM.
REQ-011 ramSel  out  1  access targets divMMC RAM.
REQ-012 ramBank  out  4  8K RAM bank index (128K total).
REQ-013 ramWe  out  1  write permitted to the selected RAM bank.

Function
REQ-014 Port 0xE3 write: on cep with !iorq, a[7:0]=0xE3 and !wr, the module SHALL latch conmem=d[7], mapram=d[6] and bank=d[3:0]; d[5:4] are ignored.
REQ-015 Port 0xE3 read: qe=!iorq && a[7:0]=0xE3 && !rd (combinational); q={conmem,mapram,2'b00,bank}.
REQ-016 Entry points 0x0000, 0x0008, 0x0038, 0x0066, 0x04C6 and 0x0562: an M1 fetch (!m1 && !mreq on cep) at one of these addresses SHALL set pending-map; automap becomes 1 on the first cep after mreq returns high (delayed mapping).
REQ-017 An M1 fetch at 0x3D00-0x3DFF SHALL set automap on the same cep edge, so the fetch is served by divMMC memory one cycle after detection (instant mapping).
REQ-018 An M1 fetch at 0x1FF8-0x1FFF SHALL set pending-unmap; automap clears on the first cep after mreq returns high.
REQ-019 The pending flags SHALL be held in a 3-state FSM: IDLE -> PEND_MAP or PEND_UNMAP on a qualifying fetch; either pending state -> IDLE at the end of the fetch (mreq high), applying the pending action.
REQ-020 If a new qualifying fetch arrives while the FSM is pending, it SHALL NOT occur, because the end of the fetch resolves the pending state first; the bench SHALL assert that no overlap occurs.
REQ-021 Simultaneous port write and automap change on the same cep: both SHALL take effect; they update independent registers.
REQ-022 map=conmem | automap.
REQ-023 With map=1 and a[15:13]=000: romSel=1 if conmem=1 or mapram=0; otherwise ramSel=1, ramBank=3 and ramWe=0.
REQ-024 With map=1 and a[15:13]=001: ramSel=1, ramBank=bank, and ramWe=!(mapram && bank==3).
REQ-025 With map=0 or a[15:14]!=00, romSel, ramSel and ramWe SHALL be 0; ramBank then holds its last value.
REQ-026 Outputs romSel, ramSel, ramBank and ramWe SHALL be combinational from the registered state and a; only the state itself is registered.

Reset
REQ-027 While reset=0: conmem=0, mapram=0, bank=0, automap=0 and FSM=IDLE; therefore map=romSel=ramSel=ramWe=0 and q=0x00.
REQ-028 Reset asserted during a pending state SHALL abandon the pending action; after release the FSM is in IDLE.

Configuration
REQ-029 Macro DIVMMC_MAPRAM_EN.
- Defined: mapram is set-only; a write with d[6]=0 does not clear it, and only reset clears it. REQ-023 and REQ-024 apply in full.
- Undefined: mapram is constantly 0; q[6] reads 0; RAM bank 3 is always writable through 0x2000-0x3FFF; 0x0000-0x1FFF always selects ROM when mapped.

Verification
REQ-030 Write 0x83 to 0xE3, read 0xE3 -> q=0x83 and qe=1. Access to 0x2000 -> ramSel=1, ramBank=3, ramWe=1. Access to 0x0000 -> romSel=1.
REQ-031 M1 fetch at 0x0038 -> map=0 during the fetch and map=1 on the first cep after mreq rises. Subsequent fetch at 0x1FFA -> map stays 1 during the fetch and drops to 0 after it.
REQ-032 M1 fetch at 0x3D2F -> map=1 on the next cep edge while mreq is still low. A non-M1 read of 0x0066 -> map unchanged.
REQ-033 With DIVMMC_MAPRAM_EN: write 0x40 then 0x03 -> q=0x43. With automap active, access 0x0100 -> ramSel=1, ramBank=3, ramWe=0. Write 0x00 -> q=0x40. Without the macro, the same sequence -> q=0x03 and romSel=1.
REQ-034 Assert reset while in PEND_MAP after a fetch at 0x0000, then release -> map=0, q=0x00, and the FSM is in IDLE.
REQ-035 Port write 0x80 coincident with the end of a 0x1FF8 fetch (unmap) -> automap=0, conmem=1, map=1.
